// File: rtl/hazard_stall_ctrl.sv
// Purpose: load-use stall, taken-branch flush and data-memory freeze sequencer for the 5-stage core.
// Latency: controls are combinational from state + inputs (same cycle); state/counters update on clk_i.
// Backpressure: Dmem_busy freezes the whole pipeline (PC_Write/IF_ID_Write low, Pipe_Freeze high).
//
// Ports:
//   clk_i, rst_i                        clock (rising edge), async active-low reset
//   IF_ID_Rs_addr/IF_ID_Rt_addr         source registers of the instruction in ID
//   ID_uses_Rt                          ID instruction reads Rt as a source
//   ID_EX_Rt_addr/ID_EX_MemRead         destination and load flag of the instruction in EX
//   Branch_taken                        branch resolved taken in MEM
//   Dmem_busy                           data memory not ready
//   PC_Write, IF_ID_Write               write enables (1 = advance)
//   ID_EX_Bubble                        zero ID/EX control fields
//   IF_ID_Flush/ID_EX_Flush/EX_Mem_Flush clear the named pipeline register
//   Pipe_Freeze                         hold every pipeline register
//   state_o                             0 RUN, 1 FLUSH, 2 MEM_WAIT
//   stall_cnt/flush_cnt                 saturating load-use stall / branch flush event counters
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_Rs_addr,
    input  logic [4:0]       IF_ID_Rt_addr,
    input  logic             ID_uses_Rt,
    input  logic [4:0]       ID_EX_Rt_addr,
    input  logic             ID_EX_MemRead,
    input  logic             Branch_taken,
    input  logic             Dmem_busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_Mem_Flush,
    output logic             Pipe_Freeze,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Remaining FLUSH cycles after the branch cycle itself: at most FLUSH_CYCLES-1.
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   fcnt;
    logic [FW-1:0]   fcnt_nxt;
    logic            stall_inc;
    logic            flush_inc;
    logic            load_use;

    // $0 is never a real dependency, so a load into $0 cannot cause a hazard.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt_addr != 5'd0) &&
                      ((ID_EX_Rt_addr == IF_ID_Rs_addr) ||
                       (ID_uses_Rt && (ID_EX_Rt_addr == IF_ID_Rt_addr)));

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_Mem_Flush = 1'b0;
        Pipe_Freeze  = 1'b0;
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        // Outputs are gated by reset so the pipeline sees plain defaults while reset is held,
        // regardless of what the (still live) hazard inputs are doing.
        if (rst_i) begin
            case (state)
                // MEM_WAIT resumes with RUN rules in the very cycle Dmem_busy drops, so a branch or
                // load-use held during the wait is acted on without an extra cycle.
                RUN, MEM_WAIT: begin
                    if (Dmem_busy) begin
                        Pipe_Freeze = 1'b1;
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        state_nxt   = MEM_WAIT;
                    end else if (Branch_taken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        EX_Mem_Flush = 1'b1;
                        flush_inc    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
                            state_nxt = FLUSH;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else if (load_use) begin
                        // The bubble clears ID_EX_MemRead next cycle, so this self-limits to one cycle.
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        stall_inc    = 1'b1;
                        state_nxt    = RUN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    if (Dmem_busy) begin
                        // Flush progress pauses with the rest of the pipeline.
                        Pipe_Freeze = 1'b1;
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                    end else begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        fcnt_nxt    = fcnt - FW'(1);
                        if (fcnt == FW'(1)) begin
                            state_nxt = RUN;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= RUN;
            fcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose: directed-vector scoreboard bench for hazard_stall_ctrl (FLUSH_CYCLES=3, CNT_W=4).
// Latency: each vector is driven on the falling edge and checked 2 time units later.
// Backpressure: none; the monitor drains one expected entry per cycle.
module tb_hazard_stall_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 4;

    // Output vector order: {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_Mem_Flush, Pipe_Freeze}
    localparam logic [6:0] DEF = 7'b1100000;
    localparam logic [6:0] STL = 7'b0010000;
    localparam logic [6:0] BR3 = 7'b1101110;
    localparam logic [6:0] FL2 = 7'b1101100;
    localparam logic [6:0] FRZ = 7'b0000001;

    typedef struct packed {
        logic [15:0]      id;
        logic [6:0]       outs;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic             clk_i;
    logic             rst_i;
    logic [4:0]       IF_ID_Rs_addr;
    logic [4:0]       IF_ID_Rt_addr;
    logic             ID_uses_Rt;
    logic [4:0]       ID_EX_Rt_addr;
    logic             ID_EX_MemRead;
    logic             Branch_taken;
    logic             Dmem_busy;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_Mem_Flush;
    logic             Pipe_Freeze;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_failed = 0;
    int   vec_id   = 0;

    hazard_stall_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .IF_ID_Rs_addr(IF_ID_Rs_addr),
        .IF_ID_Rt_addr(IF_ID_Rt_addr),
        .ID_uses_Rt   (ID_uses_Rt),
        .ID_EX_Rt_addr(ID_EX_Rt_addr),
        .ID_EX_MemRead(ID_EX_MemRead),
        .Branch_taken (Branch_taken),
        .Dmem_busy    (Dmem_busy),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .ID_EX_Bubble (ID_EX_Bubble),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .EX_Mem_Flush (EX_Mem_Flush),
        .Pipe_Freeze  (Pipe_Freeze),
        .state_o      (state_o),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Drive one cycle of inputs and queue the hand-computed response for that cycle.
    task automatic step(input logic rstn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic [4:0] ex_rt, input logic memrd,
                        input logic br, input logic busy, input logic [6:0] e_outs,
                        input logic [1:0] e_st, input int e_sc, input int e_fc);
        exp_t e;
        @(negedge clk_i);
        rst_i         = rstn;
        IF_ID_Rs_addr = rs;
        IF_ID_Rt_addr = rt;
        ID_uses_Rt    = uses_rt;
        ID_EX_Rt_addr = ex_rt;
        ID_EX_MemRead = memrd;
        Branch_taken  = br;
        Dmem_busy     = busy;
        e.id   = 16'(vec_id);
        e.outs = e_outs;
        e.st   = e_st;
        e.sc   = CNT_W'(e_sc);
        e.fc   = CNT_W'(e_fc);
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic idle(input logic [6:0] e_outs, input logic [1:0] e_st, input int e_sc, input int e_fc);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e_outs, e_st, e_sc, e_fc);
    endtask

    // Load-use hazard: lw $2 in EX, add $3,$2,$4 in ID.
    task automatic hazard(input logic [6:0] e_outs, input logic [1:0] e_st, input int e_sc, input int e_fc);
        step(1'b1, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, e_outs, e_st, e_sc, e_fc);
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle, away from the clock edge.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_Mem_Flush, Pipe_Freeze};
                n_tests++;
                if (act !== e.outs || state_o !== e.st || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_failed++;
                    $display("FAIL vec%0d: got outs=%b st=%0d stall=%0d flush=%0d, want outs=%b st=%0d stall=%0d flush=%0d",
                             e.id, act, state_o, stall_cnt, flush_cnt, e.outs, e.st, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        int sc;
        int fc;
        rst_i = 1'b0;
        IF_ID_Rs_addr = '0; IF_ID_Rt_addr = '0; ID_uses_Rt = 1'b0;
        ID_EX_Rt_addr = '0; ID_EX_MemRead = 1'b0; Branch_taken = 1'b0; Dmem_busy = 1'b0;

        // Reset held with busy/branch/load-use all live: outputs must still be defaults.
        step(1'b0, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, DEF, 2'd0, 0, 0);
        idle(DEF, 2'd0, 0, 0);

        // Single load-use stall, then defaults.
        hazard(STL, 2'd0, 0, 0);
        idle(DEF, 2'd0, 1, 0);

        // Load into $0 matching Rs=$0: no stall. Rt match but Rt not read: no stall. Then Rt read: stall.
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, DEF, 2'd0, 1, 0);
        step(1'b1, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, DEF, 2'd0, 1, 0);
        step(1'b1, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, STL, 2'd0, 1, 0);
        idle(DEF, 2'd0, 2, 0);

        // Branch pulse: full flush, then two IF_ID+ID_EX flush cycles, state 0,1,1,0.
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BR3, 2'd0, 2, 0);
        idle(FL2, 2'd1, 2, 1);
        idle(FL2, 2'd1, 2, 1);
        idle(DEF, 2'd0, 2, 1);

        // Branch with load-use in the same cycle: branch wins; FLUSH ignores both next cycle.
        step(1'b1, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, BR3, 2'd0, 2, 1);
        step(1'b1, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, FL2, 2'd1, 2, 2);
        // Counter now 1: four busy cycles freeze and hold it, then one flush cycle, then RUN.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ, 2'd1, 2, 2);
        end
        idle(FL2, 2'd1, 2, 2);
        idle(DEF, 2'd0, 2, 2);

        // Branch held through a memory wait is taken in the cycle busy drops.
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FRZ, 2'd0, 2, 2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FRZ, 2'd2, 2, 2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BR3, 2'd2, 2, 2);
        idle(FL2, 2'd1, 2, 3);
        idle(FL2, 2'd1, 2, 3);
        idle(DEF, 2'd0, 2, 3);

        // Load-use held through a memory wait: stall acted on as busy drops; freeze not counted.
        step(1'b1, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, FRZ, 2'd0, 2, 3);
        step(1'b1, 5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, STL, 2'd2, 2, 3);
        idle(DEF, 2'd0, 3, 3);

        // Stall counter saturation at 4'hF.
        sc = 3;
        for (int i = 0; i < 14; i++) begin
            hazard(STL, 2'd0, sc, 3);
            if (sc < 15) sc++;
        end
        idle(DEF, 2'd0, 15, 3);

        // Flush counter saturation at 4'hF.
        fc = 3;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BR3, 2'd0, 15, fc);
            if (fc < 15) fc++;
            idle(FL2, 2'd1, 15, fc);
            idle(FL2, 2'd1, 15, fc);
        end
        idle(DEF, 2'd0, 15, 15);

        // Reset mid-MEM_WAIT takes effect immediately, before any clock edge.
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ, 2'd0, 15, 15);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ, 2'd2, 15, 15);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, DEF, 2'd0, 0, 0);
        idle(DEF, 2'd0, 0, 0);

        // Give the monitor a bounded window to drain the queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk_i);
            #5;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
